// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions used by the writeback stage and register file.
package rv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_NONE = 2'b11
    } wb_sel_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_formatter.sv
// Extracts and sign/zero-extends the addressed byte or halfword of a raw load word.
module load_formatter #(
    parameter int XLEN = rv_pkg::XLEN
) (
    input  logic [XLEN-1:0] read_data,
    input  logic [2:0]      load_funct3,
    input  logic [1:0]      addr_low,
    output logic [XLEN-1:0] load_data
);
    import rv_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = read_data[7:0];
        unique case (addr_low)
            2'd0: byte_sel = read_data[7:0];
            2'd1: byte_sel = read_data[15:8];
            2'd2: byte_sel = read_data[23:16];
            2'd3: byte_sel = read_data[31:24];
            default: byte_sel = read_data[7:0];
        endcase
    end

    // Halfword selection ignores addr_low[0]; misalignment traps elsewhere.
    assign half_sel = addr_low[1] ? read_data[31:16] : read_data[15:0];

    always_comb begin
        load_data = '0;
        case (load_funct3)
            F3_LB:   load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:   load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LW:   load_data = read_data;
            F3_LBU:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LHU:  load_data = {{(XLEN-16){1'b0}}, half_sel};
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback source select plus 32x32 integer register file with two bypassed read ports.
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      wb_sel,
    input  logic            reg_write,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] read_data,
    input  logic [XLEN-1:0] pc_plus_four,
    input  logic [2:0]      load_funct3,
    input  logic [1:0]      addr_low,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_we
);
    import rv_pkg::*;

    logic [XLEN-1:0] load_data;
    wb_sel_t         sel;

    // x0 is never stored; index 0 is handled by the read-port logic.
    logic [XLEN-1:0] regs_q [1:NREGS-1];
    logic [XLEN-1:0] regs_d [1:NREGS-1];

    load_formatter #(.XLEN(XLEN)) u_load_formatter (
        .read_data   (read_data),
        .load_funct3 (load_funct3),
        .addr_low    (addr_low),
        .load_data   (load_data)
    );

    assign sel = wb_sel_t'(wb_sel);

    always_comb begin
        wb_data = '0;
        case (sel)
            WB_ALU:  wb_data = alu_result;
            WB_LOAD: wb_data = load_data;
            WB_PC4:  wb_data = pc_plus_four;
            default: wb_data = '0;
        endcase
    end

    assign wb_we = reg_write && (rd_addr != 5'd0) && (sel != WB_NONE) && !reset;

    always_comb begin
        for (int i = 1; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wb_we && (rd_addr == 5'(i))) begin
                regs_d[i] = wb_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 1; i < NREGS; i++) begin
            if (reset) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Same-cycle bypass lets decode see the value being committed this edge.
    always_comb begin
        rs1_data = '0;
        if (rs1_addr == 5'd0) begin
            rs1_data = '0;
        end else if (wb_we && (rd_addr == rs1_addr)) begin
            rs1_data = wb_data;
        end else begin
            rs1_data = regs_q[rs1_addr];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr == 5'd0) begin
            rs2_data = '0;
        end else if (wb_we && (rd_addr == rs2_addr)) begin
            rs2_data = wb_data;
        end else begin
            rs2_data = regs_q[rs2_addr];
        end
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage plus integer register file for the five-stage RV32I pipeline. It sits after the MEM/WB pipeline register. It selects the writeback value (ALU result, formatted load data, or PC+4) and commits it to a 32×32 register file. It also serves the two combinational read ports used by decode. Same-cycle write-to-read bypass keeps decode from seeing stale operands.

## Interface
Parameters:
- XLEN, 32, data width
- NREGS, 32, architectural registers; x0 is hardwired to zero

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- wb_sel  in  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 reserved
- reg_write  in  1  write enable from MEM/WB
- rd_addr  in  5  destination register
- alu_result  in  XLEN  ALU result from MEM/WB
- read_data  in  XLEN  raw 32-bit word from data memory, via MEM/WB
- pc_plus_four  in  XLEN  link value from MEM/WB
- load_funct3  in  3  load type: LB 000, LH 001, LW 010, LBU 100, LHU 101
- addr_low  in  2  byte offset of the load address, alu_result[1:0] as registered
- rs1_addr, rs2_addr  in  5 each  decode read addresses
- rs1_data, rs2_data  out  XLEN each  read data, combinational
- wb_data  out  XLEN  selected writeback value, combinational, for the forwarding unit
- wb_we  out  1  effective write strobe, combinational

## Operation
- Load formatting:
  - LB/LBU select byte addr_low.
  - LH/LHU select halfword addr_low[1]; addr_low[0] is ignored.
  - LW passes the word unchanged.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Any other funct3 yields 0.
- wb_data:
  - wb_sel 00 gives alu_result.
  - wb_sel 01 gives the formatted load.
  - wb_sel 10 gives pc_plus_four.
  - wb_sel 11 gives 0.
- wb_we = reg_write AND (rd_addr ≠ 0) AND (wb_sel ≠ 11) AND NOT reset.
- Register write: at posedge clk with wb_we high, regs[rd_addr] <= wb_data.
- Reset: at posedge clk with reset high, all 32 registers are cleared to 0. Reset overrides any pending write.
- Read ports:
  - rsN_data = 0 if rsN_addr = 0.
  - Otherwise wb_data if wb_we is high and rd_addr = rsN_addr (bypass).
  - Otherwise regs[rsN_addr].
- Both read ports are independent. Both may hit the bypass in the same cycle.

## Timing
- Write latency: 1 cycle. The value is visible from the array on the cycle after the edge, and through the bypass in the same cycle.
- Read latency: 0 cycles, combinational from addresses and array.
- Reset values:
  - All registers are 0.
  - rs1_data and rs2_data are 0 in the cycle after reset.
  - While reset is high, wb_we is 0, so no bypass occurs.
  - wb_data follows its inputs, since it is combinational.
- Reset asserted mid-stream: the write in that cycle is dropped. The array is zero on the next cycle.
- Writes to x0: no storage update and no bypass. A read of x0 always returns 0.
- Back-to-back writes to the same rd: the last write wins. Each is visible via bypass in its own cycle.
- wb_sel 11 with reg_write 1: no write, and wb_data is 0.
- Misaligned LW (addr_low ≠ 00): data passes unchanged. Trapping is handled elsewhere.

## Structure
- Shared package rv_pkg:
  - wb_sel_t enum: WB_ALU=2'b00, WB_LOAD=2'b01, WB_PC4=2'b10, WB_NONE=2'b11.
  - Load funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - XLEN.
- Sub-module load_formatter: purely combinational. It takes read_data, load_funct3 and addr_low, and returns the formatted XLEN value.
- The top contains the wb_sel mux, the wb_we logic, the register array (x1..x31 as flops; x0 not stored) and the two bypassed read ports.

## Test plan
- Reset: preload x1..x31 with nonzero values, assert reset one cycle → all reads return 0, including a write that was attempted during reset.
- ALU writeback: wb_sel 00, alu_result 0xDEADBEEF, rd 5, reg_write 1, rs1_addr 5 in the same cycle → rs1_data 0xDEADBEEF (bypass). Next cycle with reg_write 0 → still 0xDEADBEEF (array).
- Load formatting:
  - read_data 0x80FF1234 with LB addr_low 3 → 0xFFFFFF80.
  - LBU addr_low 3 → 0x00000080.
  - LH addr_low 2 → 0xFFFF80FF.
  - LHU addr_low 0 → 0x00001234.
  - LW → 0x80FF1234.
- PC+4 link: wb_sel 10, pc_plus_four 0x00000104, rd 1 → x1 reads 0x00000104.
- x0 and reserved cases:
  - Write 0x12345678 to rd 0 → wb_we 0 and x0 reads 0.
  - wb_sel 11 to rd 7 → x7 is unchanged and wb_data is 0.
- Dual-port hit: rs1_addr = rs2_addr = rd = 9, write 0xA5A5A5A5 → both ports show 0xA5A5A5A5 in the same cycle.
